// File: rtl/stack_sum_bcd_out.sv
// rtl/stack_sum_bcd_out.sv - FIFO-buffered binary-to-BCD converter with digit stream output
//
// Ports:
//   CLK         rising-edge clock
//   RESET       synchronous active-high reset
//   IN_VALID    one-cycle pulse qualifying IN
//   IN          DATA_W-bit sum from the stack stage
//   DOUT_READY  downstream accepts DOUT at a rising edge when high
//   DOUT_VALID  DOUT holds a valid digit
//   DOUT        BCD digit, tens first
//   DOUT_LAST   marks the ones digit (final digit of a value)
//   DROP        one-cycle pulse when a sample is lost to a full FIFO
//
// Optional: define STACK_SUM_BCD_LZS_EN to suppress a leading tens digit of 0.

module stack_sum_bcd_out #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN,
    input  logic              DOUT_READY,
    output logic              DOUT_VALID,
    output logic [3:0]        DOUT,
    output logic              DOUT_LAST,
    output logic              DROP
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int IW    = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND_TENS,
        SEND_ONES
    } state_t;

    state_t            state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] bin;
    logic [7:0]        bcd;
    logic [IW-1:0]     iter;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;

    logic [2:0]        tens_adj;
    logic [3:0]        ones_adj;
    logic [7:0]        bcd_next;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign pop   = (state == IDLE) && !empty;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    assign push  = IN_VALID && (!full || pop);

    // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin} left.
    // The tens nibble never exceeds 6 for DATA_W=6, so only its low 3 bits
    // survive the shift.
    always_comb begin
        tens_adj = (bcd[7:4] >= 4'd5) ? 3'(bcd[7:4] + 4'd3) : bcd[6:4];
        ones_adj = (bcd[3:0] >= 4'd5) ? (bcd[3:0] + 4'd3) : bcd[3:0];
        bcd_next = {tens_adj, ones_adj, bin[DATA_W-1]};
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            DROP   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            DROP <= IN_VALID && full && !pop;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            bin        <= '0;
            bcd        <= '0;
            iter       <= '0;
            DOUT_VALID <= 1'b0;
            DOUT       <= 4'd0;
            DOUT_LAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        bin   <= mem[rd_ptr];
                        bcd   <= '0;
                        iter  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bin  <= {bin[DATA_W-2:0], 1'b0};
                    bcd  <= bcd_next;
                    iter <= iter + 1'b1;
                    if (iter == IW'(DATA_W - 1)) begin
                        DOUT_VALID <= 1'b1;
`ifdef STACK_SUM_BCD_LZS_EN
                        if (bcd_next[7:4] == 4'd0) begin
                            DOUT      <= bcd_next[3:0];
                            DOUT_LAST <= 1'b1;
                            state     <= SEND_ONES;
                        end else begin
                            DOUT      <= bcd_next[7:4];
                            DOUT_LAST <= 1'b0;
                            state     <= SEND_TENS;
                        end
`else
                        DOUT      <= bcd_next[7:4];
                        DOUT_LAST <= 1'b0;
                        state     <= SEND_TENS;
`endif
                    end
                end
                SEND_TENS: begin
                    if (DOUT_READY) begin
                        DOUT      <= bcd[3:0];
                        DOUT_LAST <= 1'b1;
                        state     <= SEND_ONES;
                    end
                end
                SEND_ONES: begin
                    if (DOUT_READY) begin
                        DOUT_VALID <= 1'b0;
                        DOUT_LAST  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sum_bcd_out.sv
// tb/tb_stack_sum_bcd_out.sv - self-checking bench for stack_sum_bcd_out

module tb_stack_sum_bcd_out;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              IN_VALID;
    logic [DATA_W-1:0] IN;
    logic              DOUT_READY;
    logic              DOUT_VALID;
    logic [3:0]        DOUT;
    logic              DOUT_LAST;
    logic              DROP;

    int checks = 0;
    int passed = 0;
    int drop_cnt = 0;
    int last_cnt = 0;
    logic [4:0] got_q[$];
    logic [4:0] exp_q[$];

    stack_sum_bcd_out #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN_VALID(IN_VALID),
        .IN(IN),
        .DOUT_READY(DOUT_READY),
        .DOUT_VALID(DOUT_VALID),
        .DOUT(DOUT),
        .DOUT_LAST(DOUT_LAST),
        .DROP(DROP)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1 ns after a rising edge, so the falling edge sees what
    // the next rising edge will act on.
    always @(negedge CLK) begin
        if (!RESET && DOUT_VALID && DOUT_READY) begin
            got_q.push_back({DOUT_LAST, DOUT});
            if (DOUT_LAST) last_cnt++;
        end
        if (DROP) drop_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void expect_value(input int v);
        int t = v / 10;
        int o = v % 10;
`ifdef STACK_SUM_BCD_LZS_EN
        if (t != 0) exp_q.push_back({1'b0, 4'(t)});
`else
        exp_q.push_back({1'b0, 4'(t)});
`endif
        exp_q.push_back({1'b1, 4'(o)});
    endfunction

    function automatic int first_diff();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) return i;
        end
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        IN_VALID = 1'b0;
        IN = '0;
        DOUT_READY = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        got_q.delete();
        exp_q.delete();
        drop_cnt = 0;
        last_cnt = 0;
    endtask

    task automatic pulse(input int v);
        IN_VALID = 1'b1;
        IN = 6'(v);
        tick();
        IN_VALID = 1'b0;
        IN = 6'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!DOUT_VALID && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(output bit timeout);
        int k = 0;
        DOUT_READY = 1'b1;
        while ((got_q.size() < exp_q.size() || DOUT_VALID) && k < 500) begin
            tick();
            k++;
        end
        timeout = (k >= 500);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (DOUT_VALID !== 1'b0) $display("FAIL reset_valid: got %b required 0", DOUT_VALID); else passed++;
        checks++; if (DOUT !== 4'd0) $display("FAIL reset_dout: got %0d required 0", DOUT); else passed++;
        checks++; if (DOUT_LAST !== 1'b0) $display("FAIL reset_last: got %b required 0", DOUT_LAST); else passed++;
        checks++; if (DROP !== 1'b0) $display("FAIL reset_drop: got %b required 0", DROP); else passed++;
    endtask

    task automatic test_single();
        int n, d;
        bit to;
        do_reset();
        DOUT_READY = 1'b1;
        pulse(37);
        wait_valid(n);
        checks++; if (n != 7) $display("FAIL single_latency: got %0d edges required 7", n); else passed++;
        expect_value(37);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL single_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
        checks++; if (DOUT_VALID !== 1'b0) $display("FAIL single_idle_valid: got %b required 0", DOUT_VALID); else passed++;
        checks++; if (drop_cnt != 0) $display("FAIL single_drop: got %0d pulses required 0", drop_cnt); else passed++;
    endtask

    task automatic test_stall();
        int n, d;
        bit to;
        do_reset();
        pulse(60);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({DOUT_VALID, DOUT_LAST, DOUT} !== {1'b1, 1'b0, 4'd6})
                $display("FAIL stall_hold_%0d: got valid=%b last=%b dout=%0d required valid=1 last=0 dout=6", i, DOUT_VALID, DOUT_LAST, DOUT);
            else passed++;
            tick();
        end
        expect_value(60);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL stall_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
    endtask

    task automatic test_overflow();
        int d;
        bit to;
        do_reset();
        for (int v = 1; v <= 6; v++) pulse(v);
        checks++; if (DROP !== 1'b1) $display("FAIL overflow_drop_set: got %b required 1", DROP); else passed++;
        tick();
        checks++; if (DROP !== 1'b0) $display("FAIL overflow_drop_clear: got %b required 0", DROP); else passed++;
        for (int v = 1; v <= 5; v++) expect_value(v);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL overflow_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
        checks++; if (drop_cnt != 1) $display("FAIL overflow_drop_count: got %0d pulses required 1", drop_cnt); else passed++;
    endtask

    task automatic test_zero_and_nine();
        int d;
        bit to;
        do_reset();
        DOUT_READY = 1'b1;
        pulse(0);
        expect_value(0);
        drain(to);
        pulse(9);
        expect_value(9);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL zero_nine_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
    endtask

    task automatic test_reset_mid_send();
        int n, d;
        bit to;
        do_reset();
        pulse(11);
        pulse(22);
        pulse(33);
        wait_valid(n);
        checks++; if (DOUT_VALID !== 1'b1) $display("FAIL midreset_reach_send: got %b required 1", DOUT_VALID); else passed++;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if (DOUT_VALID !== 1'b0) $display("FAIL midreset_valid: got %b required 0", DOUT_VALID); else passed++;
        got_q.delete();
        DOUT_READY = 1'b1;
        repeat (30) tick();
        checks++; if (got_q.size() != 0) $display("FAIL midreset_residue: got %0d digits required 0", got_q.size()); else passed++;
        pulse(45);
        wait_valid(n);
        checks++; if (n != 7) $display("FAIL midreset_latency: got %0d edges required 7", n); else passed++;
        expect_value(45);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL midreset_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
    endtask

    task automatic test_full_push_pop();
        int n, d;
        bit to;
        int vals[6] = '{12, 23, 34, 45, 56, 7};
        do_reset();
        for (int i = 0; i < 5; i++) pulse(vals[i]);
        wait_valid(n);
        DOUT_READY = 1'b1;
        tick();
        tick();
        // FSM is now IDLE with DEPTH entries queued; push lands on the pop edge.
        pulse(vals[5]);
        checks++; if (DROP !== 1'b0) $display("FAIL fullpp_drop: got %b required 0", DROP); else passed++;
        for (int i = 0; i < 6; i++) expect_value(vals[i]);
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL fullpp_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
        checks++; if (drop_cnt != 0) $display("FAIL fullpp_drop_count: got %0d pulses required 0", drop_cnt); else passed++;
    endtask

    task automatic test_random();
        int issued = 0;
        int d;
        bit to;
        int v;
        do_reset();
        repeat (600) begin
            DOUT_READY = ($urandom % 4) != 0;
            if ((issued - last_cnt) < DEPTH && ($urandom % 3) == 0) begin
                v = int'($urandom % 64);
                expect_value(v);
                IN_VALID = 1'b1;
                IN = 6'(v);
                issued++;
            end else begin
                IN_VALID = 1'b0;
                IN = 6'($urandom);
            end
            tick();
        end
        IN_VALID = 1'b0;
        drain(to);
        d = first_diff();
        checks++; if (to || d != -1) $display("FAIL random_stream: got %0d digits required %0d, first difference at %0d", got_q.size(), exp_q.size(), d); else passed++;
        checks++; if (drop_cnt != 0) $display("FAIL random_drop_count: got %0d pulses required 0", drop_cnt); else passed++;
        checks++; if (DOUT_VALID !== 1'b0) $display("FAIL random_final_valid: got %b required 0", DOUT_VALID); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_overflow();
        test_zero_and_nine();
        test_reset_mid_send();
        test_full_push_pop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
